// File: rtl/aes_key_sched.sv
// AES-128 key expansion (10 cycles after start) and round-key playback (first key the cycle after go).
// No backpressure: playback emits 11 consecutive keys; start/reset preempt any activity.

module aes_sbox (
  input  logic [7:0] in_i,
  output logic [7:0] out_o
);

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign out_o = SBOX[in_i];

endmodule

module aes_key_sched (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [127:0] key,
  input  logic         dir,
  input  logic         go,
  output logic         ready,
  output logic [127:0] roundKey,
  output logic         done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXPAND,
    S_READY,
    S_PLAY,
    S_DONE
  } state_e;

  state_e       state_q, state_d;
  logic [3:0]   rnd_q;
  logic [3:0]   idx_q;
  logic         dir_q;
  logic         ready_q;
  logic         done_q;
  logic [127:0] rk_q;
  logic [127:0] kmem_q [0:10];

  logic         go_acc;
  logic         play_last;
  logic [127:0] prev_key;
  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  rot_w, sub_w, t_w;
  logic [31:0]  nw0, nw1, nw2, nw3;
  logic [7:0]   rcon;

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  assign play_last = dir_q ? (idx_q == 4'd0) : (idx_q == 4'd10);

  always_comb begin
    state_d = state_q;
    go_acc  = 1'b0;
    case (state_q)
      S_IDLE:   state_d = S_IDLE;
      S_EXPAND: if (rnd_q == 4'd10) state_d = S_READY;
      S_READY, S_DONE: begin
        if (go) begin
          state_d = S_PLAY;
          go_acc  = 1'b1;
        end
      end
      S_PLAY:   if (play_last) state_d = S_DONE;
      default:  state_d = S_IDLE;
    endcase
    // start preempts everything, including a coincident go
    if (start) begin
      state_d = S_EXPAND;
      go_acc  = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // One expansion round: kmem[rnd] from kmem[rnd-1]
  // ---------------------------------------------------------------------------
  assign prev_key = kmem_q[rnd_q - 4'd1];
  assign w0 = prev_key[127:96];
  assign w1 = prev_key[95:64];
  assign w2 = prev_key[63:32];
  assign w3 = prev_key[31:0];
  assign rot_w = {w3[23:0], w3[31:24]};

  for (genvar i = 0; i < 4; i++) begin : g_sbox
    aes_sbox u_sbox (
      .in_i  (rot_w[8*i +: 8]),
      .out_o (sub_w[8*i +: 8])
    );
  end

  always_comb begin
    rcon = 8'h00;
    case (rnd_q)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  assign t_w = sub_w ^ {rcon, 24'h000000};
  assign nw0 = w0 ^ t_w;
  assign nw1 = w1 ^ nw0;
  assign nw2 = w2 ^ nw1;
  assign nw3 = w3 ^ nw2;

  // Key memory is not reset; ready qualifies its contents.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (start) begin
        kmem_q[0] <= key;
      end else if (state_q == S_EXPAND) begin
        kmem_q[rnd_q] <= {nw0, nw1, nw2, nw3};
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State, round counter and playback registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      rnd_q   <= 4'd1;
      idx_q   <= 4'd0;
      dir_q   <= 1'b0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      rk_q    <= '0;
    end else begin
      state_q <= state_d;
      if (start) begin
        rnd_q   <= 4'd1;
        ready_q <= 1'b0;
        done_q  <= 1'b0;
        rk_q    <= '0;
      end else if (go_acc) begin
        dir_q  <= dir;
        done_q <= 1'b0;
        rk_q   <= kmem_q[dir ? 4'd10 : 4'd0];
        idx_q  <= dir ? 4'd9 : 4'd1;
      end else if (state_q == S_EXPAND) begin
        rnd_q <= rnd_q + 4'd1;
        if (rnd_q == 4'd10) ready_q <= 1'b1;
      end else if (state_q == S_PLAY) begin
        rk_q <= kmem_q[idx_q];
        if (play_last) begin
          done_q <= 1'b1;
        end else begin
          idx_q <= dir_q ? (idx_q - 4'd1) : (idx_q + 4'd1);
        end
      end
    end
  end

  assign ready    = ready_q;
  assign done     = done_q;
  assign roundKey = rk_q;

endmodule

// File: tb/tb_aes_key_sched.sv
// Directed bench for aes_key_sched using FIPS-197 key expansion vectors.
// Inputs change 1 time unit after the rising edge; outputs are checked there too.

module tb_aes_key_sched;

  logic         clk = 1'b0;
  logic         reset, start, dir, go;
  logic [127:0] key;
  logic         ready, done;
  logic [127:0] roundKey;

  int checks = 0;
  int errors = 0;

  logic [127:0] ka [0:10];
  logic [127:0] kb0, kb10;

  always #5 clk = ~clk;

  aes_key_sched dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .key      (key),
    .dir      (dir),
    .go       (go),
    .ready    (ready),
    .roundKey (roundKey),
    .done     (done)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (ready !== 1'b1 && n < 30) begin
      tick();
      n++;
    end
    chk1(tag, ready, 1'b1);
  endtask

  initial begin
    ka[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    ka[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    ka[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    ka[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    ka[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    ka[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    ka[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    ka[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    ka[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    ka[9]  = 128'hac7766f319fadc2128d12941575c006e;
    ka[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    kb0    = 128'h000102030405060708090a0b0c0d0e0f;
    kb10   = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    reset = 1'b1; start = 1'b0; go = 1'b0; dir = 1'b0; key = '0;
    tick(); tick();
    reset = 1'b0;
    chk1("rst_ready", ready, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk("rst_rk", roundKey, 128'd0);

    // Expansion latency, with an early go that must be ignored
    key = ka[0]; start = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      chk1($sformatf("ready_low_T%0d", n), ready, 1'b0);
      go = (n == 5);
      tick();
      go = 1'b0;
    end
    chk1("ready_T11", ready, 1'b1);
    chk("early_go_rk", roundKey, 128'd0);
    chk1("early_go_done", done, 1'b0);

    // Forward playback; dir toggle mid-stream must not matter
    dir = 1'b0; go = 1'b1;
    tick();
    go = 1'b0;
    for (int n = 0; n <= 10; n++) begin
      chk($sformatf("fwd_rk%0d", n), roundKey, ka[n]);
      chk1($sformatf("fwd_done%0d", n), done, n == 10);
      if (n == 5) dir = 1'b1;
      if (n < 10) tick();
    end
    tick();
    chk("fwd_hold_rk", roundKey, ka[10]);
    chk1("fwd_hold_done", done, 1'b1);

    // Reverse replay from DONE; dir toggle and go inside PLAY are ignored
    dir = 1'b1; go = 1'b1;
    tick();
    go = 1'b0;
    for (int n = 0; n <= 10; n++) begin
      chk($sformatf("rev_rk%0d", n), roundKey, ka[10-n]);
      chk1($sformatf("rev_done%0d", n), done, n == 10);
      if (n == 3) dir = 1'b0;
      go = (n == 4);
      if (n < 10) tick();
      go = 1'b0;
    end
    tick();
    chk("rev_hold_rk", roundKey, ka[0]);
    chk1("rev_hold_done", done, 1'b1);

    // New key during playback
    dir = 1'b0; go = 1'b1;
    tick();
    go = 1'b0;
    tick(); tick();
    key = kb0; start = 1'b1;
    tick();
    start = 1'b0;
    chk1("restart_ready", ready, 1'b0);
    chk1("restart_done", done, 1'b0);
    chk("restart_rk", roundKey, 128'd0);
    wait_ready("restart_wait_ready");
    chk("restart_ready_rk", roundKey, 128'd0);
    dir = 1'b0; go = 1'b1;
    tick();
    go = 1'b0;
    chk("kb_rk0", roundKey, kb0);
    for (int n = 1; n <= 10; n++) tick();
    chk("kb_rk10", roundKey, kb10);
    chk1("kb_done", done, 1'b1);

    // start and go together in READY: expansion wins
    key = ka[0]; start = 1'b1;
    tick();
    start = 1'b0;
    wait_ready("sim_wait_ready_a");
    key = kb0; start = 1'b1; go = 1'b1;
    tick();
    start = 1'b0; go = 1'b0;
    chk1("sim_ready", ready, 1'b0);
    chk1("sim_done", done, 1'b0);
    chk("sim_rk", roundKey, 128'd0);
    wait_ready("sim_wait_ready_b");
    chk("sim_no_play_rk", roundKey, 128'd0);
    chk1("sim_no_play_done", done, 1'b0);
    go = 1'b1;
    tick();
    go = 1'b0;
    for (int n = 1; n <= 10; n++) tick();
    chk("sim_kb_rk10", roundKey, kb10);

    // Reset mid-expansion
    key = ka[0]; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk1("rstx_ready", ready, 1'b0);
    chk1("rstx_done", done, 1'b0);
    chk("rstx_rk", roundKey, 128'd0);
    go = 1'b1;
    tick();
    go = 1'b0;
    tick();
    chk("rstx_go_rk", roundKey, 128'd0);
    chk1("rstx_go_done", done, 1'b0);
    chk1("rstx_go_ready", ready, 1'b0);

    // Reset mid-playback
    key = ka[0]; start = 1'b1;
    tick();
    start = 1'b0;
    wait_ready("rstp_wait_ready");
    dir = 1'b0; go = 1'b1;
    tick();
    go = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk1("rstp_ready", ready, 1'b0);
    chk1("rstp_done", done, 1'b0);
    chk("rstp_rk", roundKey, 128'd0);
    go = 1'b1;
    tick();
    go = 1'b0;
    tick(); tick();
    chk("rstp_go_rk", roundKey, 128'd0);
    chk1("rstp_go_done", done, 1'b0);
    chk1("rstp_go_ready", ready, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
